in_fifo_port: RTL and testbench

//  Input-side buffer that feeds the processor's io_in/addr_in/req_in port from a free-running

---
 rtl/in_fifo_port.sv | 119 +++++++++++
 tb/tb_in_fifo_port.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/in_fifo_port.sv
// rtl/in_fifo_port.sv - sample FIFO feeding the processor input port, with status word and fill-level interrupt
module in_fifo_port #(
  parameter  int NUBITS = 16,
  parameter  int FDEPTH = 16,
  parameter  int NUIOIN = 2,
  parameter  int DADDR  = 0,
  parameter  int SADDR  = 1,
  parameter  int ITHR   = 1,
  localparam int AW     = (NUIOIN > 1) ? $clog2(NUIOIN) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUBITS-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [AW-1:0]     addr_in,
  input  logic              req_in,
  output logic [NUBITS-1:0] io_in,
  output logic              itr,
  output logic              ovf
);

  localparam int CW = $clog2(FDEPTH + 1);
  localparam int PW = $clog2(FDEPTH);
  localparam logic [CW-1:0] FULL_C = CW'(FDEPTH);
  localparam logic [CW-1:0] ITHR_C = CW'(ITHR);

  logic [NUBITS-1:0] mem [FDEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_nxt;
  logic              udf;
  logic              full;
  logic              empty;
  logic              hit_d;
  logic              hit_s;
  logic              push;
  logic              pop;
  logic              drop;
  logic              under_rd;
  logic              stat_rd;
  logic              itr_nxt;
  logic [NUBITS-1:0] status;

  assign full     = (count == FULL_C);
  assign empty    = (count == '0);
  assign hit_d    = (addr_in == AW'(DADDR));
  assign hit_s    = (addr_in == AW'(SADDR));
  assign s_ready  = !full && !rst;
  assign push     = s_valid && s_ready;
  // Full is sampled before the edge, so a same-cycle pop never makes room for this sample.
  assign drop     = s_valid && full;
  assign pop      = req_in && hit_d && !empty;
  assign under_rd = req_in && hit_d && empty;
  assign stat_rd  = req_in && hit_s;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Rising-edge crossing of the threshold only; staying above it does not re-trigger.
  assign itr_nxt = (count < ITHR_C) && (count_nxt >= ITHR_C);

  always_comb begin
    status           = '0;
    status[CW-1:0]   = count;
    status[CW]       = empty;
    status[CW+1]     = full;
    status[CW+2]     = ovf;
    status[CW+3]     = udf;
  end

  always_comb begin
    io_in = '0;
    if (hit_s)
      io_in = status;
    else if (hit_d && !empty)
      io_in = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
      itr    <= 1'b0;
    end else begin
      count <= count_nxt;
      itr   <= itr_nxt;
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      // A fresh event on the clearing edge takes priority over the status-read clear.
      if (drop)
        ovf <= 1'b1;
      else if (stat_rd)
        ovf <= 1'b0;
      if (under_rd)
        udf <= 1'b1;
      else if (stat_rd)
        udf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_in_fifo_port.sv
// tb/tb_in_fifo_port.sv - directed self-checking bench for in_fifo_port
module tb_in_fifo_port;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [0:0]  addr_in;
  logic        req_in;
  logic [15:0] io_in;
  logic        itr;
  logic        ovf;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [0:0] DA = 1'b0;
  localparam logic [0:0] SA = 1'b1;

  in_fifo_port dut (
    .clk     (clk),
    .rst     (rst),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .addr_in (addr_in),
    .req_in  (req_in),
    .io_in   (io_in),
    .itr     (itr),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    s_data  = d;
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
  endtask

  task automatic rd(input logic [0:0] a, input logic [15:0] exp, input string tag);
    addr_in = a;
    req_in  = 1'b1;
    #1;
    chk(tag, {16'h0, io_in}, {16'h0, exp});
    step();
    req_in  = 1'b0;
  endtask

  // Status layout for FDEPTH=16: count[4:0], empty 0x20, full 0x40, ovf 0x80, udf 0x100.
  task automatic peek_status(input logic [15:0] exp, input string tag);
    addr_in = SA;
    #1;
    chk(tag, {16'h0, io_in}, {16'h0, exp});
  endtask

  initial begin
    rst = 1'b1; s_data = '0; s_valid = 1'b0; addr_in = DA; req_in = 1'b0;
    step();
    chk("rst_s_ready", {31'h0, s_ready}, 32'd0);
    chk("rst_itr", {31'h0, itr}, 32'd0);
    chk("rst_ovf", {31'h0, ovf}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_s_ready", {31'h0, s_ready}, 32'd1);
    peek_status(16'h0020, "post_rst_status");

    // 1: three pushes, single itr pulse, show-ahead reads
    push(16'h0011);
    chk("t1_itr_pulse", {31'h0, itr}, 32'd1);
    push(16'h0022);
    chk("t1_itr_low2", {31'h0, itr}, 32'd0);
    push(16'h0033);
    chk("t1_itr_low3", {31'h0, itr}, 32'd0);
    rd(DA, 16'h0011, "t1_rd0");
    rd(DA, 16'h0022, "t1_rd1");
    rd(DA, 16'h0033, "t1_rd2");
    rd(SA, 16'h0020, "t1_status");

    // 2: overflow, sticky ovf cleared by status read
    for (int i = 0; i < 18; i++) begin
      chk($sformatf("t2_s_ready_%0d", i), {31'h0, s_ready}, (i < 16) ? 32'd1 : 32'd0);
      push(16'h0100 + 16'(i));
      if (i == 0)
        chk("t2_itr_pulse", {31'h0, itr}, 32'd1);
    end
    chk("t2_ovf_flag", {31'h0, ovf}, 32'd1);
    rd(SA, 16'h00D0, "t2_status_full_ovf");
    chk("t2_ovf_cleared", {31'h0, ovf}, 32'd0);
    rd(SA, 16'h0050, "t2_status_after_clear");
    for (int i = 0; i < 16; i++)
      rd(DA, 16'h0100 + 16'(i), $sformatf("t2_drain_%0d", i));
    peek_status(16'h0020, "t2_empty");

    // 3: underflow read
    rd(DA, 16'h0000, "t3_empty_read");
    rd(SA, 16'h0120, "t3_status_udf");
    rd(SA, 16'h0020, "t3_udf_cleared");

    // 4: simultaneous push and pop at count=5
    for (int i = 0; i < 5; i++) begin
      push(16'h0040 + 16'(i));
      if (i == 0)
        chk("t4_itr_pulse", {31'h0, itr}, 32'd1);
    end
    s_data  = 16'h0045;
    s_valid = 1'b1;
    rd(DA, 16'h0040, "t4_pushpop_data");
    s_valid = 1'b0;
    chk("t4_no_itr", {31'h0, itr}, 32'd0);
    peek_status(16'h0005, "t4_count5");
    for (int i = 1; i < 6; i++)
      rd(DA, 16'h0040 + 16'(i), $sformatf("t4_drain_%0d", i));

    // 5: pointer wrap
    for (int i = 0; i < 12; i++)
      push(16'h0050 + 16'(i));
    for (int i = 0; i < 12; i++)
      rd(DA, 16'h0050 + 16'(i), $sformatf("t5_first_%0d", i));
    for (int i = 0; i < 8; i++)
      push(16'h0060 + 16'(i));
    for (int i = 0; i < 8; i++)
      rd(DA, 16'h0060 + 16'(i), $sformatf("t5_wrap_%0d", i));
    peek_status(16'h0020, "t5_empty");

    // 6: reset mid-stream
    for (int i = 0; i < 7; i++)
      push(16'h0070 + 16'(i));
    peek_status(16'h0007, "t6_count7");
    rst = 1'b1;
    #1;
    peek_status(16'h0020, "t6_rst_status");
    chk("t6_rst_s_ready", {31'h0, s_ready}, 32'd0);
    chk("t6_rst_itr", {31'h0, itr}, 32'd0);
    step();
    step();
    rst = 1'b0;
    push(16'h00AA);
    chk("t6_itr_after_rst", {31'h0, itr}, 32'd1);
    rd(DA, 16'h00AA, "t6_rd_after_rst");
    peek_status(16'h0020, "t6_final_empty");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
